jtbubl_obj_linebuf: RTL and testbench



---
 rtl/jtbubl_obj_linebuf.sv | 91 +++++++++
 tb/tb_jtbubl_obj_linebuf.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jtbubl_obj_linebuf.sv
// Ping-pong object line buffer: sprite engine fills one 256x8 bank while the
// other is scanned out and erased behind the beam; banks swap on each hblank.
module jtbubl_obj_linebuf #(
    parameter logic [3:0] TRANSP = 4'hF,
    parameter logic [7:0] BLANK  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic [7:0] hdump,
    input  logic       buf_we,
    input  logic [7:0] buf_addr,
    input  logic [7:0] buf_data,
    output logic       line_start,
    output logic       ready,
    output logic [7:0] col_addr
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0] state;
    logic [7:0] clr_cnt;
    logic       wr_bank;
    logic       lhbl_r;
    logic [7:0] bank0 [256];
    logic [7:0] bank1 [256];

    logic       run;
    logic       wr_en;
    logic       rd_en;
    logic       swap;
    logic [7:0] rd_data;

    always_comb begin
        run     = (state == RUN);
        wr_en   = run && buf_we && (buf_data[3:0] != TRANSP);
        rd_en   = run && pxl_cen && LHBL;
        swap    = run && pxl_cen && lhbl_r && !LHBL;
        rd_data = wr_bank ? bank0[hdump] : bank1[hdump];
    end

    // Write and erase always hit opposite banks, so each bank sees at most one
    // of them per cycle; the clear sweep owns both banks while not running.
    always_ff @(posedge clk) begin
        if (!run) begin
            bank0[clr_cnt] <= BLANK;
        end else begin
            if (wr_en && !wr_bank) bank0[buf_addr] <= buf_data;
            if (rd_en &&  wr_bank) bank0[hdump]    <= BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            bank1[clr_cnt] <= BLANK;
        end else begin
            if (wr_en &&  wr_bank) bank1[buf_addr] <= buf_data;
            if (rd_en && !wr_bank) bank1[hdump]    <= BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            wr_bank    <= 1'b0;
            lhbl_r     <= 1'b0;
            col_addr   <= BLANK;
            line_start <= 1'b0;
            ready      <= 1'b0;
        end else begin
            lhbl_r     <= LHBL;
            ready      <= run;
            line_start <= swap;
            case (state)
                CLEAR: begin
                    col_addr <= BLANK;
                    clr_cnt  <= clr_cnt + 8'd1;
                    if (clr_cnt == 8'hFF) state <= RUN;
                end
                default: begin
                    if (pxl_cen) col_addr <= LHBL ? rd_data : BLANK;
                    if (swap) wr_bank <= ~wr_bank;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtbubl_obj_linebuf.sv
// Directed bench for jtbubl_obj_linebuf: a bank model predicts each scanned
// pixel, expectations queue up at drive time and are popped at sample time.
module tb_jtbubl_obj_linebuf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pxl_cen;
    logic       LHBL;
    logic [7:0] hdump;
    logic       buf_we;
    logic [7:0] buf_addr;
    logic [7:0] buf_data;
    logic       line_start;
    logic       ready;
    logic [7:0] col_addr;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  m [2][256];
    int unsigned wb;
    logic [7:0]  sb [$];

    jtbubl_obj_linebuf #(.TRANSP(4'hF), .BLANK(8'hFF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl_cen   (pxl_cen),
        .LHBL      (LHBL),
        .hdump     (hdump),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .line_start(line_start),
        .ready     (ready),
        .col_addr  (col_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) m[b][a] = 8'hFF;
        wb = 0;
    endtask

    // Asserts reset mid-cycle, then times the clear sweep edge by edge.
    task automatic do_reset();
        logic bad;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        LHBL = 1'b0; pxl_cen = 1'b0; buf_we = 1'b0;
        #1;
        chk("rst_col_addr", col_addr, 8'hFF);
        chk("rst_ready", {7'd0, ready}, 8'h00);
        chk("rst_line_start", {7'd0, line_start}, 8'h00);
        model_clear();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0 || col_addr !== 8'hFF || line_start !== 1'b0) bad = 1'b1;
        end
        chk("clear_256_cycles", {7'd0, bad}, 8'h00);
        @(posedge clk);
        #1;
        chk("ready_edge_257", {7'd0, ready}, 8'h01);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pxl_cen = 1'b0; buf_we = 1'b1; buf_addr = a; buf_data = d;
        if (d[3:0] != 4'hF) m[wb][a] = d;
        @(negedge clk);
        buf_we = 1'b0;
    endtask

    // One pixel: a pxl_cen cycle (optionally with a write) then an idle cycle.
    task automatic pix(input logic [7:0] hd, input logic lh,
                       input logic we, input logic [7:0] wa, input logic [7:0] wd);
        logic sw;
        logic [7:0] exp;
        logic [7:0] got;
        @(negedge clk);
        sw  = LHBL && !lh;
        exp = lh ? m[1-wb][hd] : 8'hFF;
        if (lh) m[1-wb][hd] = 8'hFF;
        if (we && wd[3:0] != 4'hF) m[wb][wa] = wd;
        if (sw) wb = 1 - wb;
        sb.push_back(exp);
        hdump = hd; LHBL = lh; pxl_cen = 1'b1;
        buf_we = we; buf_addr = wa; buf_data = wd;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("col_addr@%h", hd), col_addr, got);
        chk("line_start_pulse", {7'd0, line_start}, {7'd0, sw});
        @(negedge clk);
        pxl_cen = 1'b0; buf_we = 1'b0;
        @(posedge clk);
        #1;
        chk("line_start_width", {7'd0, line_start}, 8'h00);
    endtask

    task automatic scan();
        for (int i = 0; i < 256; i++) pix(8'(i), 1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic blank();
        pix(8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0; hdump = '0;
        buf_we = 1'b0; buf_addr = '0; buf_data = '0;
        model_clear();
        repeat (3) @(posedge clk);
        do_reset();

        // Dirty both banks with 8'h12 through the write port, then reset.
        for (int a = 0; a < 256; a++) wr(8'(a), 8'h12);
        scan();
        blank();
        for (int a = 0; a < 256; a++) wr(8'(a), 8'h12);
        do_reset();
        scan(); blank(); scan(); blank();

        // Write/read, transparency, overwrite.
        wr(8'h10, 8'h23);
        wr(8'h20, 8'h4F);
        wr(8'h21, 8'h31);
        wr(8'h21, 8'h52);
        scan(); blank();
        scan(); blank();
        // Erase after read: this bank returns empty two lines later.
        scan(); blank();
        scan();

        // Blank sweep: only the first falling LHBL pulses line_start.
        for (int i = 0; i < 16; i++) pix(8'(i * 17), 1'b0, 1'b0, 8'h00, 8'h00);
        pix(8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        pix(8'h01, 1'b1, 1'b0, 8'h00, 8'h00);
        pix(8'h02, 1'b0, 1'b1, 8'h30, 8'h77);
        scan(); blank();

        // Mid-line reset at hdump 8'h80 showing non-blank data.
        wr(8'h80, 8'h5A);
        scan(); blank();
        for (int i = 0; i <= 8'h80; i++) pix(8'(i), 1'b1, 1'b0, 8'h00, 8'h00);
        chk("pre_reset_pixel", col_addr, 8'h5A);
        do_reset();
        scan(); blank(); scan();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
